serial_subtractor: RTL and testbench

Bit-serial borrow-ripple subtractor computing `diff = a - b - bin` over `WIDTH` bits, one bit per clock, LSB first. It is the subtract-side counterpart to the parallel carry-ripple adders in the arithmetic library. It trades latency for a single full-subtractor cell and sits behind valid/ready handshakes on both sides, so it drops into streaming datapaths.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 179 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e      : FSM state type (IDLE / RUN / DONE), 2-bit encoding
//   St*Enc       : raw state encodings used by the enum
package serial_sub_pkg;

  localparam logic [1:0] StIdleEnc = 2'b00;
  localparam logic [1:0] StRunEnc  = 2'b01;
  localparam logic [1:0] StDoneEnc = 2'b10;

  typedef enum logic [1:0] {
    StIdle = StIdleEnc,
    StRun  = StRunEnc,
    StDone = StDoneEnc
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit combinational subtractor cell, d = a - b - bin.
//   a_i, b_i : operand bits
//   bin_i    : borrow in
//   d_o      : difference bit
//   bout_o   : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial borrow-ripple subtractor, diff = a - b - bin, LSB first,
// one bit per clock, with valid/ready handshakes on input and output.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   in_valid_i  : operands presented        in_ready_o : operands can be accepted (IDLE)
//   a_i, b_i    : minuend / subtrahend       bin_i      : borrow in
//   out_valid_o : result available (DONE)    out_ready_i: downstream accepts result
//   diff_o      : difference                 bout_o     : borrow out (a < b + bin unsigned)
//   busy_o      : operation in flight (RUN or DONE)
//   ovf_o       : signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             fs_d;
  logic             fs_bout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_fs (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  assign accept   = (state_q == StIdle) && in_valid_i;
  assign last_bit = (cnt_q == LastCnt);

  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fs_d;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid_i) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state; only in_ready sees rst combinationally.
  always_comb begin
    in_ready_o  = (state_q == StIdle) && !rst_i;
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
  end

  // Datapath next-state.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_d   = a_i;
      b_d   = b_i;
      br_d  = bin_i;
      res_d = '0;
      cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a_i[WIDTH-1];
      b_msb_d = b_i[WIDTH-1];
`endif
    end else if (state_q == StRun) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = fs_bout;
      res_d = res_shift;
      cnt_d = cnt_q + CntW'(1);
      // Result registers change only here, so partial sums are never visible.
      if (last_bit) begin
        diff_d = res_shift;
        bout_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
        // The final bit computed is the result MSB.
        ovf_d = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign diff_o = diff_q;
  assign bout_o = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, self-checking bench for serial_subtractor (WIDTH = 4).
// Checks ovf_o as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(
    .WIDTH (W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .bin_i       (bin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .bout_o      (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_o       (ovf),
`endif
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, WIDTH RUN cycles, optional DONE stall, drain.
  task automatic run_op(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic bin_v, input logic [W-1:0] exp_d, input logic exp_b,
                        input logic exp_o, input int hold, input bit pulse);
    check_eq({name, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    a        = a_v;
    b        = b_v;
    bin      = bin_v;
    tick();  // accept edge E0
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (pulse && k == 1) begin
        in_valid = 1'b1;
        a        = 4'd1;
        b        = 4'd1;
      end
      if (pulse && k == 2) in_valid = 1'b0;
      check_eq({name, ".in_ready_run"}, in_ready, 0);
      check_eq({name, ".busy_run"}, busy, 1);
      tick();
      check_eq({name, ".out_valid_lat"}, out_valid, (k == W) ? 1 : 0);
    end
    in_valid = 1'b0;
    check_eq({name, ".diff"}, diff, exp_d);
    check_eq({name, ".bout"}, bout, exp_b);
`ifdef SERIAL_SUB_OVF_EN
    check_eq({name, ".ovf"}, ovf, exp_o);
`else
    if (exp_o === 1'bx) $display("note: %s ovf unknown", name);
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq({name, ".hold_valid"}, out_valid, 1);
      check_eq({name, ".hold_diff"}, diff, exp_d);
      check_eq({name, ".hold_bout"}, bout, exp_b);
      check_eq({name, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({name, ".drain_valid"}, out_valid, 0);
    check_eq({name, ".drain_in_ready"}, in_ready, 1);
    check_eq({name, ".drain_diff"}, diff, exp_d);
  endtask

  initial begin
    bit saw_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_eq("rst.in_ready", in_ready, 0);
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.diff", diff, 0);
    check_eq("rst.bout", bout, 0);
    rst = 1'b0;
    #1;
    check_eq("rst.in_ready_release", in_ready, 1);

    // -7 - 3 and 3 - (-7) both overflow 4-bit signed; -8 - 1 likewise.
    run_op("t1_9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1, 0, 1'b0);
    run_op("t2_3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 0, 1'b0);
    run_op("t3_0m0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 0, 1'b0);
    run_op("t4_8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, 0, 1'b1);
    run_op("t5_stall", 4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 5, 1'b0);

    // Reset during the second RUN cycle aborts; held diff (4) must clear.
    in_valid = 1'b1;
    a        = 4'd9;
    b        = 4'd3;
    bin      = 1'b0;
    tick();  // accept
    in_valid = 1'b0;
    tick();  // first RUN edge
    rst = 1'b1;
    tick();
    check_eq("t6.busy", busy, 0);
    check_eq("t6.out_valid", out_valid, 0);
    check_eq("t6.diff", diff, 0);
    check_eq("t6.in_ready_rst", in_ready, 0);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("t6.no_valid_pulse", saw_valid, 0);
    run_op("t6_5m5", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
